// File: rtl/encoder_8b10b.sv
// Registered IBM 8b/10b encoder with running-disparity tracking and K-character support.
// Define ENC8B10B_KIN_ERR_EN to enable the illegal-K checker driving kin_err.
module encoder_8b10b (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       kin,
  input  logic [7:0] din,
  output logic [9:0] dout,
  output logic       disp,
  output logic       kin_err
);

  logic [9:0] dout_q, dout_d;
  logic       disp_q, disp_d;
  logic [4:0] x;
  logic [2:0] y;
  logic       k_legal;
  logic       rd, rd6, rd4;
  logic       flip6, flip4, use_a7;
  logic [5:0] six_n, six;
  logic [3:0] four_n, four;
  logic [2:0] n6, n4;

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  assign x  = din[4:0];
  assign y  = din[7:5];
  assign rd = disp_q;

  assign k_legal = kin && ((x == 5'd28) ||
                   ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                    (x == 5'd29) || (x == 5'd30))));

  always_comb begin
    six_n = '0;
    unique case (x)
      5'd0:  six_n = 6'b100111;  5'd1:  six_n = 6'b011101;
      5'd2:  six_n = 6'b101101;  5'd3:  six_n = 6'b110001;
      5'd4:  six_n = 6'b110101;  5'd5:  six_n = 6'b101001;
      5'd6:  six_n = 6'b011001;  5'd7:  six_n = 6'b111000;
      5'd8:  six_n = 6'b111001;  5'd9:  six_n = 6'b100101;
      5'd10: six_n = 6'b010101;  5'd11: six_n = 6'b110100;
      5'd12: six_n = 6'b001101;  5'd13: six_n = 6'b101100;
      5'd14: six_n = 6'b011100;  5'd15: six_n = 6'b010111;
      5'd16: six_n = 6'b011011;  5'd17: six_n = 6'b100011;
      5'd18: six_n = 6'b010011;  5'd19: six_n = 6'b110010;
      5'd20: six_n = 6'b001011;  5'd21: six_n = 6'b101010;
      5'd22: six_n = 6'b011010;  5'd23: six_n = 6'b111010;
      5'd24: six_n = 6'b110011;  5'd25: six_n = 6'b100110;
      5'd26: six_n = 6'b010110;  5'd27: six_n = 6'b110110;
      5'd28: six_n = 6'b001110;  5'd29: six_n = 6'b101110;
      5'd30: six_n = 6'b011110;  5'd31: six_n = 6'b101011;
      default: six_n = '0;
    endcase
    if (k_legal && (x == 5'd28)) six_n = 6'b001111;

    // Table holds the RD- column; the RD+ column is its complement for every
    // unbalanced code plus the disparity-dependent D7 pattern.
    flip6 = (ones6(six_n) != 3'd3) || (six_n == 6'b111000);
    six   = (rd && flip6) ? ~six_n : six_n;
    n6    = ones6(six);
    rd6   = (n6 == 3'd4) ? 1'b1 : (n6 == 3'd2) ? 1'b0 : rd;

    use_a7 = (y == 3'd7) &&
             (k_legal ||
              (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    four_n = '0;
    unique case (y)
      3'd0: four_n = 4'b1011;
      3'd1: four_n = 4'b1001;
      3'd2: four_n = 4'b0101;
      3'd3: four_n = 4'b1100;
      3'd4: four_n = 4'b1101;
      3'd5: four_n = 4'b1010;
      3'd6: four_n = 4'b0110;
      3'd7: four_n = use_a7 ? 4'b0111 : 4'b1110;
      default: four_n = '0;
    endcase

    flip4 = (ones4(four_n) != 3'd2) || (four_n == 4'b1100);
    four  = (rd6 && flip4) ? ~four_n : four_n;
    // K28.1/.2/.5/.6 use the complement of the balanced data code at RD-.
    if (k_legal && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))
      four = rd6 ? four_n : ~four_n;
    n4  = ones4(four);
    rd4 = (n4 == 3'd3) ? 1'b1 : (n4 == 3'd1) ? 1'b0 : rd6;

    dout_d = {six, four};
    disp_d = rd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      disp_q <= 1'b0;
    end else if (en) begin
      dout_q <= dout_d;
      disp_q <= disp_d;
    end
  end

  assign dout = dout_q;
  assign disp = disp_q;

`ifdef ENC8B10B_KIN_ERR_EN
  logic kin_err_q, kin_err_d;

  assign kin_err_d = kin && !k_legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    kin_err_q <= 1'b0;
    else if (en) kin_err_q <= kin_err_d;
  end

  assign kin_err = kin_err_q;
`else
  assign kin_err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_8b10b.sv
// Self-checking bench for encoder_8b10b: directed test-plan cases plus random traffic
// compared against a two-column table reference model.
module tb_encoder_8b10b;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       kin = 1'b0;
  logic [7:0] din = '0;
  logic [9:0] dout;
  logic       disp;
  logic       kin_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ENC8B10B_KIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  encoder_8b10b dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .kin     (kin),
    .din     (din),
    .dout    (dout),
    .disp    (disp),
    .kin_err (kin_err)
  );

  always #5 clk = ~clk;

  // Standard 5b/6b and 3b/4b tables, both running-disparity columns written out.
  logic [5:0] t6n [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] t6p [0:31] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] d4n [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] k_list [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic [9:0] m_dout;
  logic       m_rd;
  logic       m_err;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal_k(input logic [7:0] d);
    for (int i = 0; i < 12; i++) if (k_list[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rd_after(input bit rd_in, input int ones, input int half);
    if (ones > half) return 1'b1;
    if (ones < half) return 1'b0;
    return rd_in;
  endfunction

  task automatic model_encode(input logic k, input logic [7:0] d);
    int x, y;
    bit as_k, rdm, a7;
    logic [5:0] s6;
    logic [3:0] s4;
    x    = int'(d[4:0]);
    y    = int'(d[7:5]);
    as_k = k && is_legal_k(d);
    rdm  = m_rd;
    if (as_k && x == 28) s6 = rdm ? 6'b110000 : 6'b001111;
    else                 s6 = rdm ? t6p[x] : t6n[x];
    rdm = rd_after(rdm, $countones(s6), 3);
    a7  = (!rdm && (x == 17 || x == 18 || x == 20)) || (rdm && (x == 11 || x == 13 || x == 14));
    if (as_k)                s4 = rdm ? k4p[y] : k4n[y];
    else if (y == 7 && a7)   s4 = rdm ? 4'b1000 : 4'b0111;
    else                     s4 = rdm ? d4p[y] : d4n[y];
    rdm    = rd_after(rdm, $countones(s4), 2);
    m_dout = {s6, s4};
    m_rd   = rdm;
    m_err  = ERR_EN && k && !as_k;
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_rd   = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".dout"}, dout, m_dout);
    check_eq({tag, ".disp"}, {9'b0, disp}, {9'b0, m_rd});
    check_eq({tag, ".kerr"}, {9'b0, kin_err}, {9'b0, m_err});
  endtask

  task automatic step(input logic e, input logic k, input logic [7:0] d);
    @(negedge clk);
    en  = e;
    kin = k;
    din = d;
    @(posedge clk);
    #1;
    if (e) model_encode(k, d);
  endtask

  task automatic step_exp(input string tag, input logic k, input logic [7:0] d,
                          input logic [9:0] exp_dout, input logic exp_disp, input logic exp_err);
    step(1'b1, k, d);
    check_eq({tag, ".dout"}, dout, exp_dout);
    check_eq({tag, ".disp"}, {9'b0, disp}, {9'b0, exp_disp});
    check_eq({tag, ".kerr"}, {9'b0, kin_err}, {9'b0, exp_err});
  endtask

  task automatic sync_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("reset.dout", dout, 10'h000);
    check_eq("reset.disp", {9'b0, disp}, 10'h000);
    check_eq("reset.kerr", {9'b0, kin_err}, 10'h000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hBC);
      check_eq("idle.dout", dout, 10'h000);
      check_eq("idle.disp", {9'b0, disp}, 10'h000);
    end

    step_exp("k28_2a", 1'b1, 8'h5C, 10'h0F5, 1'b1, 1'b0);
    step_exp("k28_2b", 1'b1, 8'h5C, 10'h30A, 1'b0, 1'b0);
    step_exp("k28_2c", 1'b1, 8'h5C, 10'h0F5, 1'b1, 1'b0);
    step_exp("k28_2d", 1'b1, 8'h5C, 10'h30A, 1'b0, 1'b0);
    step_exp("k28_5a", 1'b1, 8'hBC, 10'h0FA, 1'b1, 1'b0);
    step_exp("k28_5b", 1'b1, 8'hBC, 10'h305, 1'b0, 1'b0);
    step_exp("d21_5",  1'b0, 8'hB5, 10'h2AA, 1'b0, 1'b0);
    step_exp("d0_0",   1'b0, 8'h00, 10'h274, 1'b0, 1'b0);
    step_exp("d17_7",  1'b0, 8'hF1, 10'h237, 1'b1, 1'b0);

    sync_reset();
    step_exp("illk",   1'b1, 8'h00, 10'h274, 1'b0, ERR_EN);
    step_exp("illk_clr", 1'b1, 8'hBC, 10'h0FA, 1'b1, 1'b0);

    sync_reset();
    step_exp("hold_k", 1'b1, 8'h5C, 10'h0F5, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check_eq("hold.dout", dout, 10'h0F5);
      check_eq("hold.disp", {9'b0, disp}, 10'h001);
    end

    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst.dout", dout, 10'h000);
    check_eq("arst.disp", {9'b0, disp}, 10'h000);
    check_eq("arst.kerr", {9'b0, kin_err}, 10'h000);
    #2;
    rst = 1'b1;
    model_reset();
    step_exp("post_rst", 1'b1, 8'h5C, 10'h0F5, 1'b1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      int sel;
      logic e, k;
      logic [7:0] d;
      sel = int'($urandom_range(0, 99));
      e   = ($urandom_range(0, 3) != 0);
      if (sel < 60) begin
        k = 1'b0;
        d = 8'($urandom);
      end else if (sel < 85) begin
        k = 1'b1;
        d = k_list[$urandom_range(0, 11)];
      end else begin
        k = 1'b1;
        d = 8'($urandom);
      end
      if (i == 300) sync_reset();
      step(e, k, d);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
